// File: rtl/fsm_input_sequencer.sv
// Table-driven stimulus/checker for a 3-bit input FSM: plays (code, expected) pairs, counts mismatches.
// Optional FSM_SEQ_ERRCAP_EN adds first-error index capture outputs.
module fsm_input_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LAT   = 1,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [2:0]       wr_code,
    input  logic [2:0]       wr_exp,
    input  logic [AW:0]      len,
    input  logic             loop,
    input  logic             start,
    input  logic             abort,
    output logic [2:0]       user_input,
    input  logic [2:0]       fsm_out,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
`ifdef FSM_SEQ_ERRCAP_EN
    ,
    output logic             first_err_valid,
    output logic [AW-1:0]    first_err_idx
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic [2:0]       r_code [DEPTH];
    logic [2:0]       r_exp  [DEPTH];
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_len;
    logic             r_loop;
    logic [2:0]       r_dcnt;
    logic [2:0]       r_ui;
    logic             r_busy;
    logic             r_done;
    logic             r_mis;
    logic [ERR_W-1:0] r_err;
    // stage 0 is aligned with user_input, stage LAT with fsm_out
    logic             r_pv [LAT+1];
    logic [2:0]       r_pe [LAT+1];
`ifdef FSM_SEQ_ERRCAP_EN
    logic [AW-1:0]    r_pi [LAT+1];
    logic             r_fev;
    logic [AW-1:0]    r_fidx;
`endif

    logic          w_wr_ok;
    logic          w_len_ok;
    logic          w_start;
    logic          w_abort;
    logic          w_last;
    logic [AW-1:0] w_nidx;
    logic [2:0]    w_code0;
    logic [2:0]    w_exp0;
    logic          w_hit;

    assign w_wr_ok  = wr_en && (r_state == S_IDLE || r_state == S_DONE);
    assign w_len_ok = (len != '0) && (len <= (AW+1)'(DEPTH));
    assign w_start  = start && (r_state == S_IDLE) && w_len_ok;
    assign w_abort  = abort && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_last   = ({1'b0, r_idx} == r_len - 1'b1);
    assign w_nidx   = w_last ? '0 : r_idx + 1'b1;
    // a same-edge write to entry 0 must be visible to the first code played
    assign w_code0  = (w_wr_ok && wr_addr == '0) ? wr_code : r_code[0];
    assign w_exp0   = (w_wr_ok && wr_addr == '0) ? wr_exp  : r_exp[0];
    assign w_hit    = r_pv[LAT] && (fsm_out != r_pe[LAT]) && !w_abort;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_code[wr_addr] <= wr_code;
            r_exp[wr_addr]  <= wr_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_dcnt  <= '0;
            r_ui    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= '0;
            for (int j = 0; j <= LAT; j++) begin
                r_pv[j] <= 1'b0;
                r_pe[j] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_mis  <= w_hit;
            if (w_hit && r_err != '1)
                r_err <= r_err + 1'b1;
            for (int j = 1; j <= LAT; j++) begin
                r_pv[j] <= r_pv[j-1];
                r_pe[j] <= r_pe[j-1];
            end
            unique case (r_state)
                S_IDLE: begin
                    r_ui    <= '0;
                    r_pv[0] <= 1'b0;
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_len   <= len;
                        r_loop  <= loop;
                        r_err   <= '0;
                        r_busy  <= 1'b1;
                        r_ui    <= w_code0;
                        r_pv[0] <= 1'b1;
                        r_pe[0] <= w_exp0;
                    end
                end
                S_RUN: begin
                    if (!w_last || r_loop) begin
                        r_idx   <= w_nidx;
                        r_ui    <= r_code[w_nidx];
                        r_pv[0] <= 1'b1;
                        r_pe[0] <= r_exp[w_nidx];
                    end else begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                        r_ui    <= '0;
                        r_pv[0] <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_pv[0] <= 1'b0;
                    if (r_dcnt == 3'(LAT - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_pv[0] <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_abort) begin
                r_state <= S_IDLE;
                r_ui    <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                for (int j = 0; j <= LAT; j++)
                    r_pv[j] <= 1'b0;
            end
        end
    end

`ifdef FSM_SEQ_ERRCAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fev  <= 1'b0;
            r_fidx <= '0;
            for (int j = 0; j <= LAT; j++)
                r_pi[j] <= '0;
        end else begin
            r_pi[0] <= w_start ? '0 : w_nidx;
            for (int j = 1; j <= LAT; j++)
                r_pi[j] <= r_pi[j-1];
            if (w_hit && !r_fev) begin
                r_fev  <= 1'b1;
                r_fidx <= r_pi[LAT];
            end
            if (w_start) begin
                r_fev  <= 1'b0;
                r_fidx <= '0;
            end
        end
    end

    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fidx;
`endif

    assign user_input = r_ui;
    assign busy       = r_busy;
    assign done       = r_done;
    assign mismatch   = r_mis;
    assign err_cnt    = r_err;

endmodule

// File: tb/tb_fsm_input_sequencer.sv
// Scoreboard bench for fsm_input_sequencer; FSM model answers user_input+1 one cycle later.
// Define FSM_SEQ_ERRCAP_EN to also check first-error capture.
module tb_fsm_input_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int LAT   = 1;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [2:0]       wr_code = '0;
    logic [2:0]       wr_exp = '0;
    logic [AW:0]      len = '0;
    logic             loop = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [2:0]       user_input;
    logic [2:0]       fsm_out = '0;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;
`ifdef FSM_SEQ_ERRCAP_EN
    logic             first_err_valid;
    logic [AW-1:0]    first_err_idx;
`endif

    bit         force7 = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [2:0] tbl_code [DEPTH];

    typedef struct {
        logic [2:0] ui;
        logic       busy;
        logic       done;
    } exp_t;
    exp_t q[$];

    fsm_input_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .LAT(LAT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_code(wr_code), .wr_exp(wr_exp),
        .len(len), .loop(loop),
        .start(start), .abort(abort),
        .user_input(user_input), .fsm_out(fsm_out),
        .busy(busy), .done(done),
        .mismatch(mismatch), .err_cnt(err_cnt)
`ifdef FSM_SEQ_ERRCAP_EN
        ,
        .first_err_valid(first_err_valid),
        .first_err_idx(first_err_idx)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        fsm_out <= force7 ? 3'd7 : user_input + 3'd1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [2:0] c, input logic [2:0] e);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_code = c;
        wr_exp = e;
        tbl_code[a] = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic play(input int n, input int exp_mis);
        exp_t e;
        int   nm;
        int   nd;
        for (int c = 0; c < n; c++) q.push_back('{tbl_code[c], 1'b1, 1'b0});
        for (int c = 0; c < LAT; c++) q.push_back('{3'd0, 1'b1, 1'b0});
        q.push_back('{3'd0, 1'b0, 1'b1});
        q.push_back('{3'd0, 1'b0, 1'b0});
        len = (AW+1)'(n);
        loop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        nm = 0;
        nd = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            check("ui", user_input, e.ui);
            check("busy", busy, e.busy);
            nm += int'(mismatch);
            nd += int'(done);
            if (e.done) check("done", done, 1);
            tick();
        end
        check("mis_pulses", nm, exp_mis);
        check("done_pulses", nd, 1);
        check("err_cnt", err_cnt, exp_mis);
    endtask

    initial begin
        exp_t e;
        int   nm;
        int   nd;
        tick();
        check("rst_ui", user_input, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mis", mismatch, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++)
            wr(i, 3'(i + 1), 3'(i + 2));

        play(4, 0);
`ifdef FSM_SEQ_ERRCAP_EN
        check("cap_v_clean", first_err_valid, 0);
`endif

        wr(2, 3'd3, 3'd7);
        play(4, 1);
`ifdef FSM_SEQ_ERRCAP_EN
        check("cap_v", first_err_valid, 1);
        check("cap_idx", first_err_idx, 2);
`endif
        wr(2, 3'd3, 3'd4);

        // loop run against a broken FSM, aborted in RUN cycle 7
        force7 = 1'b1;
        for (int c = 0; c < 8; c++) q.push_back('{tbl_code[c % 3], 1'b1, 1'b0});
        q.push_back('{3'd0, 1'b0, 1'b0});
        len = 4'd3;
        loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            e = q.pop_front();
            check("loop_ui", user_input, e.ui);
            check("loop_busy", busy, e.busy);
            if (c == 7) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        e = q.pop_front();
        check("abort_ui", user_input, e.ui);
        check("abort_busy", busy, e.busy);
        check("abort_err", err_cnt, 6);
`ifdef FSM_SEQ_ERRCAP_EN
        check("loop_cap_idx", first_err_idx, 0);
`endif
        nm = 0;
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            nm += int'(mismatch);
            nd += int'(done);
            tick();
        end
        check("abort_no_mis", nm, 0);
        check("abort_no_done", nd, 0);
        check("abort_err_hold", err_cnt, 6);

        // saturation: all-zero expectations, forced 7 responses
        for (int i = 0; i < 3; i++) wr(i, tbl_code[i], 3'd0);
        len = 4'd3;
        loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300; c++) tick();
        check("sat_err", err_cnt, 255);
        check("sat_mis", mismatch, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("sat_hold", err_cnt, 255);
        force7 = 1'b0;
        for (int i = 0; i < 3; i++) wr(i, tbl_code[i], 3'(i + 2));

        // illegal lengths
        len = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_busy", busy, 0);
        check("len0_ui", user_input, 0);
        len = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len9_busy", busy, 0);
        check("len9_ui", user_input, 0);
        check("ign_err", err_cnt, 255);

        // write while busy is dropped
        len = 4'd4;
        loop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_code = 3'd6;
        wr_exp = 3'd7;
        tick();
        wr_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        play(4, 0);

        // write and start together: new entry 0 is played
        tbl_code[0] = 3'd5;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_code = 3'd5;
        wr_exp = 3'd6;
        play(4, 0);

        // asynchronous reset mid-run
        len = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ui", user_input, 0);
        check("arst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_input_sequencer.md
Name: fsm_input_sequencer

Overview:
- Stimulus side of the 3-bit FSM user-input interface. Drives the `user_input` code into a downstream FSM and checks the FSM's 3-bit `out` response.
- Holds a small programmable table of (code, expected response) pairs. On `start` it plays the table once, or continuously in loop mode.
- Compares each FSM response LAT cycles after the matching code was driven, and counts mismatches.
- Sits beside the FSM as its self-test / bring-up driver.

Parameters:
DEPTH, 8, number of table entries (power of 2, >= 2)
AW, 3, table address width = log2(DEPTH)
LAT, 1, cycles from a code appearing on user_input to its response being valid on fsm_out (1..4)
ERR_W, 8, width of the error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  table write strobe (honoured only when busy=0)
wr_addr  input  AW  table entry to write
wr_code  input  3  stimulus code to store
wr_exp  input  3  expected FSM response to store
len  input  AW+1  number of entries to play, valid range 1..DEPTH
loop  input  1  1 = wrap to entry 0 after the last entry; sampled at start
start  input  1  begin playback (honoured only in IDLE)
abort  input  1  stop playback immediately
user_input  output  3  code driven to the FSM, registered
fsm_out  input  3  FSM response
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse at normal completion
mismatch  output  1  one-cycle pulse on each failed compare
err_cnt  output  ERR_W  saturating mismatch count

Behaviour:
- Reset (async, rst_n=0) values:
  - State is IDLE.
  - user_input=0, busy=0, done=0, mismatch=0, err_cnt=0.
  - Index and compare pipeline are cleared.
  - Table contents are not reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - user_input=0.
  - start=1 with 1<=len<=DEPTH moves to RUN: idx=0, err_cnt cleared, len and loop latched.
  - start with len=0 or len>DEPTH is ignored.
- RUN:
  - In the k-th RUN cycle (k from 0), user_input=code[idx]. The code is registered, so it appears the cycle after the state enters or idx advances.
  - idx increments by one each cycle.
  - At idx=len-1 with loop=0: the next state is DRAIN.
  - At idx=len-1 with loop=1: idx wraps to 0 and the state stays in RUN.
- Compare pipeline:
  - A valid bit and the expected value travel LAT stages alongside each driven code.
  - When a valid entry exits, fsm_out is compared with it.
  - On inequality: mismatch pulses the same cycle and err_cnt increments, saturating at all-ones.
- DRAIN:
  - user_input=0.
  - Lasts exactly LAT cycles so every driven code is checked.
  - Then goes to DONE.
- DONE: done=1 for one cycle, then IDLE. err_cnt holds its value until the next accepted start.
- abort:
  - Priority over everything in RUN and DRAIN.
  - Next cycle: state is IDLE, user_input=0, pipeline valids are flushed, no compares happen, and done stays 0.
  - err_cnt keeps the count accumulated so far.
  - abort in IDLE or DONE has no effect.
- Writes:
  - wr_en in IDLE or DONE writes the table on that edge.
  - wr_en while busy=1 is dropped.
  - A write and start in the same cycle: the write lands first, and playback reads the new contents.
- start while busy is ignored. start in the DONE cycle is ignored.
- Latency: the first compare happens LAT+1 cycles after the start edge. A len=N non-loop run has busy high for N+LAT cycles.

Optional Feature:
- Macro: FSM_SEQ_ERRCAP_EN.
- When defined, adds two outputs:
  - first_err_valid (1 bit)
  - first_err_idx (AW bits)
- On the first mismatch after an accepted start:
  - Capture the table index of the failing entry and set first_err_valid.
  - Later mismatches do not overwrite the capture.
- Both outputs are cleared on reset and on an accepted start.
- When not defined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Table codes {1,2,3,4} with matching fsm_out model, len=4, loop=0 -> user_input shows 1,2,3,4; busy high for 5 cycles (LAT=1); done pulses once; err_cnt=0.
- Same run with the entry-2 expected value corrupted to 7 -> exactly one mismatch pulse; err_cnt=1; with FSM_SEQ_ERRCAP_EN, first_err_idx=2 and first_err_valid=1.
- len=3, loop=1, abort asserted on the 8th RUN cycle -> user_input sequence 1,2,3,1,2,3,1,... then 0 the cycle after abort; no done; no further compares.
- Forced fsm_out=7 against all-zero expectations, loop=1, ERR_W=8, 300 cycles -> err_cnt saturates at 255 and does not wrap.
- start with len=0, then start with len=9 (DEPTH=8) -> both ignored; busy stays 0; user_input stays 0.
- wr_en to entry 0 while busy -> table unchanged (rerun plays the old code); rst_n pulsed low mid-RUN -> user_input=0 and busy=0 immediately without waiting for a clock.
